// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IFU) and
// load/store (LSU). Accepts one request at a time, drives the memory port
// for LATENCY cycles, captures read data and holds it on the granted
// master's response channel until that master takes it.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin selection on simultaneous requests
//                  undefined -> fixed priority, LSU over IFU
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the selected master sees req_ready
// BUSY  | memory port driven from latched request; counter runs down to 0
// RESP  | captured data offered to the granted master until resp_ready

`timescale 1ns/1ps

module mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_resp_data,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_resp_data,

  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range_err
    $error("mem_arbiter: LATENCY=%0d is outside the legal range 1..15", LATENCY);
  end

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        grant_q;      // 0 = IFU, 1 = LSU
  logic [31:0] resp_q;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  logic        sel_lsu;
  logic        sel_ifu;
  logic        idle_open;
  logic        in_busy;
  logic        in_resp;
  logic        resp_taken;

`ifdef MEM_ARB_RR_EN
  // Master granted most recently; starts at LSU so IFU takes the first tie.
  logic        last_q;
  assign sel_lsu = lsu_req_valid && (!ifu_req_valid || !last_q);
`else
  assign sel_lsu = lsu_req_valid;
`endif
  assign sel_ifu = ifu_req_valid && !sel_lsu;

  // Holding reset forces every output low, even before the first reset edge
  // has moved the state register back to IDLE.
  assign idle_open = reset && (state_q == IDLE);
  assign in_busy   = reset && (state_q == BUSY);
  assign in_resp   = reset && (state_q == RESP);

  assign ifu_req_ready = idle_open && sel_ifu;
  assign lsu_req_ready = idle_open && sel_lsu;

  assign resp_taken = grant_q ? lsu_resp_ready : ifu_resp_ready;

  // Arbitration / transaction sequencing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
      resp_q  <= 32'd0;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_req_ready || lsu_req_ready) begin
            grant_q <= sel_lsu;
            addr_q  <= sel_lsu ? lsu_req_addr : ifu_req_addr;
            wen_q   <= sel_lsu && lsu_req_wen;
            wdata_q <= sel_lsu ? lsu_req_wdata : 32'd0;
            wmask_q <= sel_lsu ? lsu_req_wmask : 4'd0;
            cnt_q   <= LAT_M1;
            state_q <= BUSY;
`ifdef MEM_ARB_RR_EN
            last_q  <= sel_lsu;
`endif
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            resp_q  <= mem_rdata;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Returning to IDLE here leaves the handshake cycle itself closed
          // to new requests, giving one bubble between transactions.
          if (resp_taken) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory port: driven only while BUSY; the write strobe fires once, on the
  // last BUSY cycle, so a store is written exactly one time.
  always_comb begin
    mem_valid = in_busy;
    mem_wen   = in_busy && wen_q && (cnt_q == 4'd0);
    mem_addr  = in_busy ? addr_q  : 32'd0;
    mem_wdata = in_busy ? wdata_q : 32'd0;
    mem_wmask = in_busy ? wmask_q : 4'd0;
  end

  // Response channels: only the granted master sees valid data.
  always_comb begin
    ifu_resp_valid = in_resp && !grant_q;
    lsu_resp_valid = in_resp && grant_q;
    ifu_resp_data  = ifu_resp_valid ? resp_q : 32'd0;
    lsu_resp_data  = lsu_resp_valid ? resp_q : 32'd0;
  end

endmodule
